// File: rtl/run_step_controller_pkg.sv
// rtl/run_step_controller_pkg.sv - shared state encodings and widths for the run/step controller
package run_step_controller_pkg;

  localparam int STATE_W = 2;
  localparam int ISSUE_W = 16;

  typedef enum logic [STATE_W-1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

endpackage

// File: rtl/run_step_controller_if.sv
// rtl/run_step_controller_if.sv - front-panel buttons, CPU halt and enable/status bundle
interface run_step_controller_if;
  import run_step_controller_pkg::*;

  logic               btn_mode;
  logic               btn_step;
  logic               cpu_halt;
  logic               cpu_en;
  logic               running;
  logic [ISSUE_W-1:0] issue_count;

  modport master (
    output btn_mode, btn_step, cpu_halt,
    input  cpu_en, running, issue_count
  );

  modport slave (
    input  btn_mode, btn_step, cpu_halt,
    output cpu_en, running, issue_count
  );

endinterface

// File: rtl/run_step_controller_debounce_channel.sv
// rtl/run_step_controller_debounce_channel.sv - 2-FF synchronizer, debounce counter and rising-edge press pulse
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press
);

  logic             q1;
  logic             q2;
  logic             stable;
  logic             stable_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1          <= 1'b0;
      q2          <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      cnt         <= '0;
    end else begin
      q1          <= in;
      q2          <= q1;
      stable_prev <= stable;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = stable & ~stable_prev;

endmodule

// File: rtl/run_step_controller.sv
// rtl/run_step_controller.sv - HALT/RUN/STEP clock-enable FSM with debounced buttons and issue counter
module run_step_controller
  import run_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  run_step_controller_if.slave  bus
);

  logic               mode_press;
  logic               step_press;
  state_t             state_q;
  state_t             state_d;
  logic               cpu_en_c;
  logic               running_c;
  logic [ISSUE_W-1:0] issue_q;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .in    (bus.btn_mode),
    .press (mode_press)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step (
    .clk   (clk),
    .rst   (rst),
    .in    (bus.btn_step),
    .press (step_press)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HALT;
    else     state_q <= state_d;
  end

  // cpu_halt blocks entering RUN but not stepping, so software can step past a break.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        if (mode_press && !bus.cpu_halt) state_d = S_RUN;
        else if (step_press)             state_d = S_STEP;
      end
      S_RUN:   if (mode_press || bus.cpu_halt) state_d = S_HALT;
      S_STEP:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    cpu_en_c  = (state_q == S_RUN) || (state_q == S_STEP);
    running_c = (state_q == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst)           issue_q <= '0;
    else if (cpu_en_c) issue_q <= issue_q + ISSUE_W'(1);
  end

  assign bus.cpu_en      = cpu_en_c;
  assign bus.running     = running_c;
  assign bus.issue_count = issue_q;

endmodule

// File: tb/tb_run_step_controller.sv
// tb/tb_run_step_controller.sv - randomized and directed checks of run_step_controller against a window-based model
module tb_run_step_controller;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  run_step_controller_if bus();

  run_step_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: a button level is accepted once the last D synchronized samples all disagree with it.
  bit          pin_hist[2][$];
  bit          q2_hist[2][$];
  bit          m_stable[2];
  bit          m_rose[2];
  bit          m_run;
  bit          m_step;
  logic [15:0] m_count;

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      pin_hist[ch].delete();
      pin_hist[ch].push_back(1'b0);
      pin_hist[ch].push_back(1'b0);
      q2_hist[ch].delete();
      m_stable[ch] = 1'b0;
      m_rose[ch]   = 1'b0;
    end
    m_run   = 1'b0;
    m_step  = 1'b0;
    m_count = 16'h0000;
  endfunction

  function automatic void model_edge(input bit mode, input bit step, input bit halt, input bit r);
    bit mp;
    bit sp;
    if (r) begin
      model_reset();
      return;
    end
    mp = m_rose[0];
    sp = m_rose[1];
    if (m_run || m_step) m_count = m_count + 16'h0001;
    if (m_step) begin
      m_step = 1'b0;
    end else if (m_run) begin
      if (mp || halt) m_run = 1'b0;
    end else if (mp && !halt) begin
      m_run = 1'b1;
    end else if (sp) begin
      m_step = 1'b1;
    end
    for (int ch = 0; ch < 2; ch++) begin
      bit p;
      bit q2;
      bit all_diff;
      p  = (ch == 0) ? mode : step;
      q2 = pin_hist[ch][pin_hist[ch].size() - 2];
      pin_hist[ch].push_back(p);
      if (pin_hist[ch].size() > 4) void'(pin_hist[ch].pop_front());
      q2_hist[ch].push_back(q2);
      if (q2_hist[ch].size() > D) void'(q2_hist[ch].pop_front());
      all_diff = (q2_hist[ch].size() == D);
      for (int i = 0; i < q2_hist[ch].size(); i++)
        if (q2_hist[ch][i] == m_stable[ch]) all_diff = 1'b0;
      m_rose[ch] = all_diff && !m_stable[ch];
      if (all_diff) m_stable[ch] = ~m_stable[ch];
    end
  endfunction

  task automatic cyc(input bit mode, input bit step, input bit halt, input bit r);
    bus.btn_mode = mode;
    bus.btn_step = step;
    bus.cpu_halt = halt;
    rst          = r;
    @(posedge clk);
    model_edge(mode, step, halt, r);
    #1;
    check("cpu_en", {31'd0, bus.cpu_en}, {31'd0, (m_run || m_step)});
    check("running", {31'd0, bus.running}, {31'd0, m_run});
    check("issue_count", {16'd0, bus.issue_count}, {16'd0, m_count});
  endtask

  task automatic hold(input bit mode, input bit step, input bit halt, input int n);
    for (int i = 0; i < n; i++) cyc(mode, step, halt, 1'b0);
  endtask

  initial begin
    int n;
    int pulses;
    int run_len;
    int max_run;
    bit m;
    bit s;
    bit h;

    bus.btn_mode = 1'b0;
    bus.btn_step = 1'b0;
    bus.cpu_halt = 1'b0;
    rst          = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    hold(0, 0, 0, 50);

    // Mode press latency: first edge with pin high is edge 1, cpu_en must be up after edge D+3.
    n = 0;
    do begin
      cyc(1, 0, 0, 0);
      n++;
    end while (!bus.cpu_en && n < 50);
    check("mode_latency", n, D + 3);
    hold(1, 0, 0, 20 - n);
    hold(0, 0, 0, 10);
    hold(1, 0, 0, 10);
    hold(0, 0, 0, 10);
    check("mode_toggle_off", {31'd0, bus.running}, 32'd0);

    // Three step presses give three isolated single-cycle enables.
    cyc(0, 0, 0, 1);
    pulses  = 0;
    run_len = 0;
    max_run = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        cyc(0, (i < 10), 0, 0);
        if (bus.cpu_en) begin
          run_len++;
          if (run_len == 1) pulses++;
          if (run_len > max_run) max_run = run_len;
        end else begin
          run_len = 0;
        end
      end
    end
    check("step_pulses", pulses, 3);
    check("step_pulse_width", max_run, 1);
    check("step_issue", {16'd0, bus.issue_count}, 32'd3);

    // Glitches shorter than the debounce window.
    for (int g = 1; g <= 3; g++)
      for (int r = 0; r < 5; r++) begin
        hold(1, 0, 0, g);
        hold(0, 0, 0, g);
      end
    check("glitch_halted", {31'd0, bus.cpu_en}, 32'd0);

    // cpu_halt during RUN, then ignored mode press and an honored step press.
    cyc(0, 0, 0, 1);
    hold(1, 0, 0, 10);
    hold(0, 0, 0, 5);
    check("halt_pre_run", {31'd0, bus.running}, 32'd1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("halt_stops", {31'd0, bus.cpu_en}, 32'd0);
    hold(1, 0, 1, 10);
    hold(0, 0, 1, 10);
    check("halt_mode_ignored", {31'd0, bus.running}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, (i < 10), 1, 0);
      if (bus.cpu_en) pulses++;
    end
    check("halt_step_pulse", pulses, 1);

    // Random button activity, halts and occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) cyc(m, s, h, 1);
      hold(m, s, h, $urandom_range(1, 12));
    end

    // Counter wrap, then reset while running.
    cyc(0, 0, 0, 1);
    n = 0;
    do begin
      cyc(1, 0, 0, 0);
      n++;
    end while (!bus.running && n < 50);
    check("wrap_enter_run", {31'd0, bus.running}, 32'd1);
    hold(1, 0, 0, 5);
    for (int i = 0; i < 70000 && m_count != 16'hFFFE; i++) cyc(0, 0, 0, 0);
    check("wrap_reach", {16'd0, bus.issue_count}, 32'h0000FFFE);
    hold(0, 0, 0, 3);
    check("wrap_value", {16'd0, bus.issue_count}, 32'h00000001);
    cyc(0, 0, 0, 1);
    check("rst_run_en", {31'd0, bus.cpu_en}, 32'd0);
    check("rst_run_count", {16'd0, bus.issue_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_step_controller.md
# run_step_controller

Front-panel execution controller for the pipelined CPU. It takes two raw asynchronous push-buttons (run/halt toggle, single-step) and synchronizes and debounces each one. A three-state FSM then drives the CPU's clock-enable, either continuously (RUN) or for exactly one cycle per step press (STEP). It sits between the board I/O and the CPU core's global enable, and exports an issue counter for the VGA status display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized cycles required to accept a level change; legal range ≥ 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw asynchronous run/halt toggle button, active-high.
- btn_step  in  1  raw asynchronous single-step button, active-high.
- cpu_halt  in  1  synchronous level from the CPU (break/syscall); forces and holds HALT.
- cpu_en  out  1  CPU clock-enable.
- running  out  1  high while the FSM is in RUN.
- issue_count  out  16  number of cycles with cpu_en high, modulo 2^16.

## Operation
- Each button channel is a 2-FF synchronizer (q1, q2), then a debounce stage.
  - The debounce stage holds a `stable` level and a CNT_W-bit counter.
  - When q2 == stable, the counter clears to 0.
  - When q2 != stable and counter == DEBOUNCE_CYCLES-1, stable flips and the counter clears.
  - Otherwise the counter increments.
- Each channel has a `press` pulse = stable & ~stable_prev, where stable_prev is a register. It is one cycle wide and fires on the rising edge only; releases produce nothing.
- FSM states: S_HALT (2'd0), S_RUN (2'd1), S_STEP (2'd2). Code 2'd3 is illegal and recovers to S_HALT on the next edge.
  - S_HALT: mode_press with cpu_halt low → S_RUN. Otherwise step_press → S_STEP. Otherwise stay.
  - S_RUN: mode_press or cpu_halt → S_HALT.
  - S_STEP: → S_HALT unconditionally after one cycle.
- Simultaneous events:
  - mode_press and step_press together in S_HALT: mode wins.
  - In S_HALT with cpu_halt high: mode_press is ignored; step_press is still honored, which is how software steps past a break.
  - Presses arriving while in S_STEP are dropped.
- cpu_en = (state == S_RUN) | (state == S_STEP), decoded from the state register; it is glitch-free and carries no combinational path from the inputs.
- running = (state == S_RUN).
- issue_count increments on every edge where cpu_en is high; it wraps 16'hFFFF → 16'h0000.

## Timing
- Reset values: state = S_HALT, cpu_en = 0, running = 0, issue_count = 0. Also cleared: q1, q2, stable, stable_prev, and all debounce counters.
- Reset mid-operation (RUN or STEP) returns to HALT at that edge.
- A button held through reset is accepted only after the full debounce period following reset release.
- Latency: if q1 first captures 1 at edge k and the pin stays high:
  - q2 = 1 after edge k+1.
  - stable = 1 after edge k+1+D; press is high during the following cycle.
  - State changes after edge k+2+D, so cpu_en rises D+2 edges after edge k.
- A glitch shorter than D cycles at q2 never changes stable.
- Single step gives exactly one cycle of cpu_en per accepted press.
- cpu_halt asserted during RUN: cpu_en is low from the next cycle onward.

## Structure
- A shared package holds:
  - state encodings S_HALT, S_RUN, S_STEP, with a 2-bit state width;
  - the issue counter width (16).
- One sub-module, debounce_channel (params DEBOUNCE_CYCLES, CNT_W; ports clk, rst, in, press), containing the 2-FF sync, counter, stable and stable_prev. It is instantiated twice.
- The FSM and issue counter live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and CNT_W = 3.
- Reset, then no input: cpu_en = 0, running = 0, issue_count = 0 for 50 cycles.
- btn_mode high for 20 cycles starting before edge k: cpu_en rises after edge k+6 and stays high. Release, then press again: cpu_en falls, and issue_count equals the number of high cycles.
- btn_step pulsed 3 times, each held 10 cycles: cpu_en shows exactly 3 single-cycle pulses, and issue_count = 3.
- Glitches on btn_mode of 1–3 cycles with equal gaps: state stays S_HALT, cpu_en = 0.
- In RUN, assert cpu_halt: cpu_en = 0 from the next cycle. A mode press with cpu_halt high is ignored. A step press gives one cpu_en pulse.
- Force issue_count to 16'hFFFE, then run 3 cycles: the counter reads 16'h0001. Assert rst in RUN: the next cycle has cpu_en = 0 and issue_count = 0.
